gpi_debouncer: RTL and testbench
================================

Name: gpi_debouncer

Overview:
- Conditions raw board inputs (slide switches, keys) before they reach the processor core's general-purpose input port.
- Each bit is synchronised into the CPU clock domain, then debounced with its own counter.
- Outputs are a clean level vector plus single-cycle rise and fall pulses per bit.
- Sits directly upstream of the core; oSTABLE drives the core's GPI input.

Parameters:
- WIDTH, 8: number of input bits.
- DEBOUNCE_CYCLES, 250000: consecutive cycles a new synchronised level must persist before it is accepted. Legal range is 1 to 2^24-1; values outside that range are a static error.
- RESET_VALUE, 0 (WIDTH bits): reset value of the synchroniser flops and oSTABLE.

Ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iRAW  in  WIDTH  raw asynchronous inputs.
- iCLR  in  WIDTH  sticky-clear strobes (used only with GPI_STICKY_EN).
- oSTABLE  out  WIDTH  debounced levels.
- oRISE  out  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- oFALL  out  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- oCHANGED  out  1  OR of (oRISE | oFALL), registered in the same cycle as the pulses.
- oSTICKY  out  WIDTH  latched rise events (GPI_STICKY_EN only).

Behaviour:
- Reset (async assert, release synchronous to iCLK):
  - Synchroniser stages s1 and s2 = RESET_VALUE; oSTABLE = RESET_VALUE.
  - All counters = 0; oRISE, oFALL, oCHANGED, oSTICKY = 0.
- Synchroniser: two flops per bit, s1 <= iRAW, s2 <= s1. No other logic reads iRAW.
- Per-bit counter, cnt[i], width ceil(log2(DEBOUNCE_CYCLES+1)):
  - If s2[i] == oSTABLE[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: oSTABLE[i] <= s2[i]; cnt[i] <= 0; pulse fires.
  - Else: cnt[i] <= cnt[i] + 1.
- Bounce: any cycle where s2 returns to oSTABLE clears the count. Acceptance therefore requires DEBOUNCE_CYCLES consecutive mismatching cycles.
- Latency: oSTABLE[i] changes at the (DEBOUNCE_CYCLES+2)-th rising edge counted from the first edge that samples the new iRAW value.
- Pulse rules:
  - oRISE[i] / oFALL[i] are high for exactly the one cycle following the edge that updates oSTABLE[i]; otherwise 0.
  - oRISE and oFALL are never simultaneously high for the same bit.
  - Bits are fully independent; several bits may pulse in the same cycle, and oCHANGED is a single pulse in that case.
- Counter never wraps: its maximum is DEBOUNCE_CYCLES-1, after which it returns to 0.
- Steady input that differs from RESET_VALUE after reset: accepted after the normal latency and produces the corresponding rise/fall pulse. This is intended.
- Reset mid-count: the count is discarded and the outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: GPI_STICKY_EN.
- Defined:
  - oSTICKY[i] is set on the cycle oRISE[i] is high and holds until iCLR[i] is sampled high.
  - Set and clear in the same cycle: set wins, so oSTICKY[i] stays 1.
  - Clear with no set: oSTICKY[i] is 0 on the next cycle.
- Undefined: no sticky register is built; oSTICKY is tied to 0 and iCLR is ignored. Port list is unchanged in both cases.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VALUE=0):
- Reset with iRAW=0 held: all outputs 0 throughout. Assert iRST asynchronously mid-cycle -> outputs 0 with no clock edge.
- iRAW[0] 0->1, held -> oSTABLE[0]=1 at the 6th edge after the first sampling edge; oRISE[0]=1 and oCHANGED=1 for exactly one cycle; other bits unchanged.
- iRAW[3] toggles 1 for 3 cycles, 0 for 1 cycle, repeated 5 times -> oSTABLE[3] stays 0 and no pulses. Then hold 1 -> accepted after the full latency.
- iRAW 0x00 -> 0xA5 in one cycle, held -> oSTABLE=0xA5, oRISE=0xA5 in the same cycle, a single oCHANGED pulse. Then 0xA5 -> 0x00 -> oFALL=0xA5.
- iRST asserted while cnt[1]=2 and iRAW[1]=1 held, then released -> oSTABLE[1] rises a full latency (6 edges) after release, not earlier.
- GPI_STICKY_EN defined:
  - Rise on bit 2 -> oSTICKY=0x04.
  - iCLR=0x04 on the same cycle as a second oRISE[2] -> oSTICKY stays 0x04.
  - iCLR=0x04 alone -> oSTICKY=0x00 on the next cycle.
  - Macro undefined: oSTICKY constant 0.

Source files
------------

// File: rtl/gpi_debouncer.sv
// Two-flop synchroniser plus per-bit debounce counter for raw board inputs.
// Optional GPI_STICKY_EN macro adds sticky rise-event latches with per-bit clear.

module gpi_debouncer_lane #(
    parameter int unsigned      CNT_W   = 1,
    parameter logic [CNT_W-1:0] CNT_MAX = '0,
    parameter logic             RST_BIT = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic sync_in,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic accept
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept_d;

    // Any cycle agreeing with the accepted level restarts the run.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        accept_d = 1'b0;
        if (sync_in == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            stable_d = sync_in;
            rise_d   = sync_in;
            fall_d   = ~sync_in;
            accept_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt_q    <= '0;
            stable_q <= RST_BIT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign accept = accept_d;
endmodule

module gpi_debouncer #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 250000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iRAW,
    input  logic [WIDTH-1:0] iCLR,
    output logic [WIDTH-1:0] oSTABLE,
    output logic [WIDTH-1:0] oRISE,
    output logic [WIDTH-1:0] oFALL,
    output logic             oCHANGED,
    output logic [WIDTH-1:0] oSTICKY
);
    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_cfg
        $error("gpi_debouncer: DEBOUNCE_CYCLES must be in 1..2^24-1");
    end

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] accept_vec;

    always_comb begin
        s1_d = iRAW;
        s2_d = s1_q;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_q <= RESET_VALUE;
            s2_q <= RESET_VALUE;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpi_debouncer_lane #(
            .CNT_W   (CNT_W),
            .CNT_MAX (CNT_MAX),
            .RST_BIT (RESET_VALUE[i])
        ) u_lane (
            .iCLK    (iCLK),
            .iRST    (iRST),
            .sync_in (s2_q[i]),
            .stable  (oSTABLE[i]),
            .rise    (oRISE[i]),
            .fall    (oFALL[i]),
            .accept  (accept_vec[i])
        );
    end

    // Registered alongside the per-bit pulses so it lines up with them.
    always_comb changed_d = |accept_vec;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) changed_q <= 1'b0;
        else      changed_q <= changed_d;
    end

    assign oCHANGED = changed_q;

`ifdef GPI_STICKY_EN
    logic [WIDTH-1:0] sticky_q, sticky_d;

    // A rise pulse present in the same cycle as a clear overrides it.
    always_comb sticky_d = (sticky_q & ~iCLR) | oRISE;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) sticky_q <= '0;
        else      sticky_q <= sticky_d;
    end

    assign oSTICKY = sticky_q;
`else
    logic unused_clr;
    assign unused_clr = ^iCLR;
    assign oSTICKY    = '0;
`endif
endmodule

// File: tb/tb_gpi_debouncer.sv
// Scoreboard bench for gpi_debouncer at WIDTH=8, DEBOUNCE_CYCLES=4; works with or
// without GPI_STICKY_EN.
module tb_gpi_debouncer;
    typedef struct packed {
        logic [7:0] stable;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
        logic [7:0] sticky;
    } exp_t;

`ifdef GPI_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       iCLK, iRST;
    logic [7:0] iRAW, iCLR;
    logic [7:0] oSTABLE, oRISE, oFALL, oSTICKY;
    logic       oCHANGED;
    exp_t       act;
    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;

    gpi_debouncer #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (8'h00)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iRAW     (iRAW),
        .iCLR     (iCLR),
        .oSTABLE  (oSTABLE),
        .oRISE    (oRISE),
        .oFALL    (oFALL),
        .oCHANGED (oCHANGED),
        .oSTICKY  (oSTICKY)
    );

    assign act = {oSTABLE, oRISE, oFALL, oCHANGED, oSTICKY};

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    function automatic string fmt(exp_t v);
        return $sformatf("st=%h rise=%h fall=%h chg=%b sticky=%h",
                         v.stable, v.rise, v.fall, v.chg, v.sticky);
    endfunction

    task automatic do_reset();
        iRST = 1'b1; iRAW = 8'h00; iCLR = 8'h00;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        iRST = 1'b1; iRAW = 8'h00; iCLR = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) iRST = 1'b0;
            exp_q.push_back('0);
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL reset k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_rise();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            iRAW = 8'h01;
            exp_q.push_back('{stable: (k >= 6) ? 8'h01 : 8'h00,
                              rise:   (k == 6) ? 8'h01 : 8'h00,
                              fall:   8'h00,
                              chg:    (k == 6),
                              sticky: (STK && k >= 7) ? 8'h01 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL rise0 k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_async_reset();
        // Called with oSTABLE[0]=1; reset lands between edges.
        #3 iRST = 1'b1;
        #1;
        total++;
        if (act !== exp_t'(0)) begin
            bad++;
            $display("FAIL async_reset got %s want all zero", fmt(act));
        end
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
        iRAW = 8'h00;
    endtask

    task automatic test_bounce();
        exp_t e;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            iRAW = ((k % 4) == 3) ? 8'h00 : 8'h08;
            exp_q.push_back('0);
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL bounce k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
        for (int k = 1; k <= 8; k++) begin
            iRAW = 8'h08;
            exp_q.push_back('{stable: (k >= 6) ? 8'h08 : 8'h00,
                              rise:   (k == 6) ? 8'h08 : 8'h00,
                              fall:   8'h00,
                              chg:    (k == 6),
                              sticky: (STK && k >= 7) ? 8'h08 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL bounce_hold k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_multi_bit();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            iRAW = 8'hA5;
            exp_q.push_back('{stable: (k >= 6) ? 8'hA5 : 8'h00,
                              rise:   (k == 6) ? 8'hA5 : 8'h00,
                              fall:   8'h00,
                              chg:    (k == 6),
                              sticky: (STK && k >= 7) ? 8'hA5 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL multi_rise k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
        for (int k = 1; k <= 8; k++) begin
            iRAW = 8'h00;
            exp_q.push_back('{stable: (k >= 6) ? 8'h00 : 8'hA5,
                              rise:   8'h00,
                              fall:   (k == 6) ? 8'hA5 : 8'h00,
                              chg:    (k == 6),
                              sticky: STK ? 8'hA5 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL multi_fall k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_reset_midcount();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            iRAW = 8'h02;
            exp_q.push_back('0);
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL midcount_pre k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
        #3 iRST = 1'b1;
        #1;
        total++;
        if (act !== exp_t'(0)) begin
            bad++;
            $display("FAIL midcount_async got %s want all zero", fmt(act));
        end
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            iRAW = 8'h02;
            exp_q.push_back('{stable: (k >= 6) ? 8'h02 : 8'h00,
                              rise:   (k == 6) ? 8'h02 : 8'h00,
                              fall:   8'h00,
                              chg:    (k == 6),
                              sticky: (STK && k >= 7) ? 8'h02 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL midcount_post k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_sticky();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            iRAW = 8'h04;
            exp_q.push_back('{stable: (k >= 6) ? 8'h04 : 8'h00,
                              rise:   (k == 6) ? 8'h04 : 8'h00,
                              fall:   8'h00,
                              chg:    (k == 6),
                              sticky: (STK && k >= 7) ? 8'h04 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL sticky_set k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
        for (int k = 1; k <= 7; k++) begin
            iRAW = 8'h00;
            exp_q.push_back('{stable: (k >= 6) ? 8'h00 : 8'h04,
                              rise:   8'h00,
                              fall:   (k == 6) ? 8'h04 : 8'h00,
                              chg:    (k == 6),
                              sticky: STK ? 8'h04 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL sticky_hold k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
        for (int k = 1; k <= 9; k++) begin
            iRAW = 8'h04;
            iCLR = (k == 7 || k == 8) ? 8'h04 : 8'h00;
            exp_q.push_back('{stable: (k >= 6) ? 8'h04 : 8'h00,
                              rise:   (k == 6) ? 8'h04 : 8'h00,
                              fall:   8'h00,
                              chg:    (k == 6),
                              sticky: (STK && k <= 7) ? 8'h04 : 8'h00});
            @(posedge iCLK); #1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL sticky_clr k=%0d got %s want %s", k, fmt(act), fmt(e));
            end
        end
        iCLR = 8'h00;
    endtask

    initial begin
        iRST = 1'b1; iRAW = 8'h00; iCLR = 8'h00;
        test_reset();
        test_rise();
        test_async_reset();
        test_bounce();
        test_multi_bit();
        test_reset_midcount();
        test_sticky();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
